mbisr_repair_mem: RTL and testbench
===================================

Name: mbisr_repair_mem

Overview:
- Responder end of the MBIST memory interface: a 32x8 word array with spare words, stuck-at fault injection and a repair map.
- Serves mem_en/mem_we/mem_addr/mem_wdata requests and returns mem_rdata.
- Learns failing addresses from the BIST fail_valid/fail_addr pulses and redirects later accesses to spare words, so a re-run of the March C- sequence passes.

Parameters:
- ADDR_WIDTH, 5, main array address width (depth = 2**ADDR_WIDTH).
- DATA_WIDTH, 8, word width.
- NUM_SPARES, 2, number of spare words / repair-map entries.
- NUM_FAULTS, 2, number of stuck-at injection slots.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mem_en  in  1  access enable
- mem_we  in  1  write enable (qualified by mem_en)
- mem_addr  in  ADDR_WIDTH  access address
- mem_wdata  in  DATA_WIDTH  write data
- mem_rdata  out  DATA_WIDTH  read data
- fail_valid  in  1  one-cycle fail pulse from BIST
- fail_addr  in  ADDR_WIDTH  failing address
- repair_en  in  1  allow allocation on fail_valid
- repair_clear  in  1  invalidate all map entries
- inj_valid  in  1  load a fault slot
- inj_slot  in  $clog2(NUM_FAULTS)  slot index
- inj_addr  in  ADDR_WIDTH  faulty address
- inj_bit  in  $clog2(DATA_WIDTH)  faulty bit
- inj_val  in  1  stuck-at value
- inj_clear  in  1  invalidate all fault slots
- repair_count  out  $clog2(NUM_SPARES+1)  allocated entries
- repair_overflow  out  1  sticky: fail seen with no spare free

Behaviour:
- Clock and reset: single clock clk; rst is synchronous and active-high.
- Reset values:
  - repair_count = 0, repair_overflow = 0.
  - All map entries and fault slots invalid.
  - Array and spare contents are not reset.
  - rst mid-access: the map is cleared at that edge and any write in that cycle is dropped.
- Read path:
  - Combinational from mem_addr (zero-latency). BIST samples mem_rdata at the edge after it drives the address.
  - mem_en = 0 gives mem_rdata = 0.
  - mem_addr hits a valid map entry: return that spare word.
  - Otherwise: return the array word, with each valid fault slot matching mem_addr forcing bit inj_bit to inj_val.
- Write path (edge, mem_en & mem_we):
  - Address mapped: write the spare word.
  - Otherwise: write the array. Stuck bits remain forced on read.
- Allocation, checked at the edge with fail_valid & repair_en:
  - fail_addr already mapped: no change.
  - Otherwise, if a free entry exists: take the lowest-index free entry, store fail_addr, set valid, load the spare with 0, repair_count += 1.
  - Otherwise (no free entry): repair_overflow <= 1, held until rst.
- Same edge, write to fail_addr during allocation: the new spare takes mem_wdata instead of 0. Redirection becomes visible the cycle after allocation.
- repair_clear: invalidates all entries and sets repair_count = 0; repair_overflow is kept. If fail_valid arrives in the same cycle, clear wins and nothing is allocated.
- inj_valid: writes slot inj_slot {addr, bit, val, valid=1}.
- inj_clear: invalidates all slots; it wins over inj_valid in the same cycle.
- Map state machine per entry: FREE -> MAPPED on allocation; MAPPED -> FREE on rst/repair_clear.

Optional Feature:
- MBISR_FAULT_INJ_EN:
  - Defined: fault slots and read-side forcing exist as above.
  - Undefined: slots are not built, inj_* inputs are ignored, and array reads return stored data.

Decomposition:
- Package mbisr_pkg: ADDR_WIDTH/DATA_WIDTH defaults, NUM_SPARES, NUM_FAULTS, repair-entry struct {valid, addr}, fault-slot struct {valid, addr, bit, val}.
- Sub-module mbisr_repair_cam:
  - Holds the map entries.
  - Does the lookup (hit, index), free-entry priority encode, duplicate check, count and overflow logic.

Test Plan:
- Write 0xA5 to addr 3, read addr 3 -> mem_rdata = 0xA5 the same cycle; mem_en=0 -> 0x00.
- Inject addr 7 bit 2 stuck-at-1, write 0x00, read -> 0x04. inj_clear, then read -> 0x00.
- fail_valid with fail_addr = 7, repair_en = 1 -> repair_count = 1. Write 0x00 to addr 7, read -> 0x00 (spare, fault bypassed).
- fail_valid on 7 twice -> repair_count stays 1. Fails on 9, then 12 -> count = 2, then overflow = 1.
- Full March C- pass with two injected faults, repair, second pass -> second pass reports no fail_valid.
- repair_clear together with fail_valid on 5 -> repair_count = 0, no entry for 5.
- rst mid-run -> count 0, map empty, overflow 0.

Source files
------------

// File: rtl/mbisr_pkg.sv
// Shared sizes and record types for the MBIST repair memory.
package mbisr_pkg;

  localparam int ADDR_WIDTH  = 5;
  localparam int DATA_WIDTH  = 8;
  localparam int NUM_SPARES  = 2;
  localparam int NUM_FAULTS  = 2;
  localparam int DEPTH       = 2 ** ADDR_WIDTH;
  localparam int SPARE_IDX_W = (NUM_SPARES > 1) ? $clog2(NUM_SPARES) : 1;
  localparam int FAULT_IDX_W = (NUM_FAULTS > 1) ? $clog2(NUM_FAULTS) : 1;
  localparam int BIT_IDX_W   = $clog2(DATA_WIDTH);
  localparam int COUNT_W     = $clog2(NUM_SPARES + 1);

  typedef enum logic {
    MAP_FREE   = 1'b0,
    MAP_MAPPED = 1'b1
  } map_state_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
  } repair_entry_t;

  typedef struct packed {
    logic                  valid;
    logic [ADDR_WIDTH-1:0] addr;
    logic [BIT_IDX_W-1:0]  bit_idx;
    logic                  val;
  } fault_slot_t;

endpackage

// File: rtl/mbisr_repair_mem_if.sv
// BIST-to-memory access bus; the BIST drives requests, the memory returns read data.
interface mbisr_repair_mem_if;

  logic                             mem_en;
  logic                             mem_we;
  logic [mbisr_pkg::ADDR_WIDTH-1:0] mem_addr;
  logic [mbisr_pkg::DATA_WIDTH-1:0] mem_wdata;
  logic [mbisr_pkg::DATA_WIDTH-1:0] mem_rdata;

  modport master (output mem_en, output mem_we, output mem_addr, output mem_wdata, input mem_rdata);
  modport slave  (input mem_en, input mem_we, input mem_addr, input mem_wdata, output mem_rdata);

endinterface

// File: rtl/mbisr_repair_cam.sv
// Repair map: address lookup, lowest-free allocation, duplicate filtering,
// allocated-entry count and sticky overflow flag.
module mbisr_repair_cam
  import mbisr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [ADDR_WIDTH-1:0]  lookup_addr,
  output logic                   lookup_hit,
  output logic [SPARE_IDX_W-1:0] lookup_idx,
  input  logic                   fail_valid,
  input  logic [ADDR_WIDTH-1:0]  fail_addr,
  input  logic                   repair_en,
  input  logic                   repair_clear,
  output logic                   alloc,
  output logic [SPARE_IDX_W-1:0] alloc_idx,
  output logic [COUNT_W-1:0]     repair_count,
  output logic                   repair_overflow
);

  repair_entry_t      entry_q [NUM_SPARES];
  repair_entry_t      entry_d [NUM_SPARES];
  logic [COUNT_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               dup, free_found, fail_req;
  logic [SPARE_IDX_W-1:0] free_idx;

  // Lookup, duplicate check and lowest-index free search (downward scan, last hit wins).
  always_comb begin
    lookup_hit = 1'b0;
    lookup_idx = '0;
    dup        = 1'b0;
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = NUM_SPARES - 1; i >= 0; i--) begin
      lookup_hit = lookup_hit | (entry_q[i].valid & (entry_q[i].addr == lookup_addr));
      lookup_idx = (entry_q[i].valid && entry_q[i].addr == lookup_addr) ? SPARE_IDX_W'(i) : lookup_idx;
      dup        = dup | (entry_q[i].valid & (entry_q[i].addr == fail_addr));
      free_found = free_found | ~entry_q[i].valid;
      free_idx   = (!entry_q[i].valid) ? SPARE_IDX_W'(i) : free_idx;
    end
    fail_req   = fail_valid & repair_en & ~repair_clear & ~dup;
    alloc      = fail_req & free_found;
    alloc_idx  = free_idx;
    overflow_d = overflow_q | (fail_req & ~free_found);
  end

  // Per-entry FREE/MAPPED transitions and the allocated-entry counter.
  always_comb begin
    entry_d = entry_q;
    count_d = count_q;
    if (repair_clear) begin
      count_d = '0;
    end else if (alloc) begin
      count_d = count_q + COUNT_W'(1);
    end else begin
      count_d = count_q;
    end
    for (int i = 0; i < NUM_SPARES; i++) begin
      case (map_state_t'(entry_q[i].valid))
        MAP_FREE: begin
          if (alloc && free_idx == SPARE_IDX_W'(i)) begin
            entry_d[i] = '{valid: 1'b1, addr: fail_addr};
          end else begin
            entry_d[i] = entry_q[i];
          end
        end
        MAP_MAPPED: begin
          if (repair_clear) begin
            entry_d[i].valid = 1'b0;
          end else begin
            entry_d[i] = entry_q[i];
          end
        end
        default: entry_d[i] = entry_q[i];
      endcase
    end
  end

  // Map, count and overflow registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SPARES; i++) begin
        entry_q[i] <= '{valid: 1'b0, addr: '0};
      end
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      entry_q    <= entry_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  assign repair_count    = count_q;
  assign repair_overflow = overflow_q;

endmodule

// File: rtl/mbisr_repair_mem.sv
// 32x8 memory with spare-word redirection driven by BIST fail reports.
// Stuck-at fault injection slots are built only when MBISR_FAULT_INJ_EN is defined.
module mbisr_repair_mem
  import mbisr_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  mbisr_repair_mem_if.slave      mem,
  input  logic                   fail_valid,
  input  logic [ADDR_WIDTH-1:0]  fail_addr,
  input  logic                   repair_en,
  input  logic                   repair_clear,
  input  logic                   inj_valid,
  input  logic [FAULT_IDX_W-1:0] inj_slot,
  input  logic [ADDR_WIDTH-1:0]  inj_addr,
  input  logic [BIT_IDX_W-1:0]   inj_bit,
  input  logic                   inj_val,
  input  logic                   inj_clear,
  output logic [COUNT_W-1:0]     repair_count,
  output logic                   repair_overflow
);

  logic [DATA_WIDTH-1:0]  array_q [DEPTH];
  logic [DATA_WIDTH-1:0]  spare_q [NUM_SPARES];
  logic                   hit, alloc, alloc_ld, wr_req, array_we, spare_we;
  logic [SPARE_IDX_W-1:0] hit_idx, alloc_idx;
  logic [DATA_WIDTH-1:0]  alloc_wdata, array_rdata, rdata;

  mbisr_repair_cam u_cam (
    .clk             (clk),
    .rst             (rst),
    .lookup_addr     (mem.mem_addr),
    .lookup_hit      (hit),
    .lookup_idx      (hit_idx),
    .fail_valid      (fail_valid),
    .fail_addr       (fail_addr),
    .repair_en       (repair_en),
    .repair_clear    (repair_clear),
    .alloc           (alloc),
    .alloc_idx       (alloc_idx),
    .repair_count    (repair_count),
    .repair_overflow (repair_overflow)
  );

  // Write steering; a write landing on the address being allocated seeds the new spare.
  always_comb begin
    wr_req      = mem.mem_en & mem.mem_we & ~rst;
    spare_we    = wr_req & hit;
    array_we    = wr_req & ~hit;
    alloc_ld    = alloc & ~rst;
    alloc_wdata = (wr_req && mem.mem_addr == fail_addr) ? mem.mem_wdata : '0;
  end

  // Storage arrays carry no reset.
  always_ff @(posedge clk) begin
    if (array_we) begin
      array_q[mem.mem_addr] <= mem.mem_wdata;
    end
    for (int i = 0; i < NUM_SPARES; i++) begin
      if (alloc_ld && alloc_idx == SPARE_IDX_W'(i)) begin
        spare_q[i] <= alloc_wdata;
      end else if (spare_we && hit_idx == SPARE_IDX_W'(i)) begin
        spare_q[i] <= mem.mem_wdata;
      end
    end
  end

`ifdef MBISR_FAULT_INJ_EN
  fault_slot_t fault_q [NUM_FAULTS];
  fault_slot_t fault_d [NUM_FAULTS];

  // Slot loading; a clear overrides a load in the same cycle.
  always_comb begin
    fault_d = fault_q;
    for (int i = 0; i < NUM_FAULTS; i++) begin
      if (inj_clear) begin
        fault_d[i].valid = 1'b0;
      end else if (inj_valid && inj_slot == FAULT_IDX_W'(i)) begin
        fault_d[i] = '{valid: 1'b1, addr: inj_addr, bit_idx: inj_bit, val: inj_val};
      end else begin
        fault_d[i] = fault_q[i];
      end
    end
  end

  // Fault slot registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_FAULTS; i++) begin
        fault_q[i] <= '{valid: 1'b0, addr: '0, bit_idx: '0, val: 1'b0};
      end
    end else begin
      fault_q <= fault_d;
    end
  end

  // Array read with stuck bits forced.
  always_comb begin
    array_rdata = array_q[mem.mem_addr];
    for (int i = 0; i < NUM_FAULTS; i++) begin
      array_rdata[fault_q[i].bit_idx] = (fault_q[i].valid && fault_q[i].addr == mem.mem_addr) ?
                                        fault_q[i].val : array_rdata[fault_q[i].bit_idx];
    end
  end
`else
  logic inj_unused;

  assign inj_unused = ^{inj_valid, inj_slot, inj_addr, inj_bit, inj_val, inj_clear};

  // Array read of stored data.
  always_comb begin
    array_rdata = array_q[mem.mem_addr];
  end
`endif

  // Zero-latency read mux: disabled, spare, or array.
  always_comb begin
    rdata = '0;
    if (!mem.mem_en) begin
      rdata = '0;
    end else if (hit) begin
      rdata = spare_q[hit_idx];
    end else begin
      rdata = array_rdata;
    end
  end

  assign mem.mem_rdata = rdata;

endmodule

// File: tb/tb_mbisr_repair_mem.sv
// Directed bench for mbisr_repair_mem: reads, injection, repair map, March C-, reset.
module tb_mbisr_repair_mem;
  import mbisr_pkg::*;

`ifdef MBISR_FAULT_INJ_EN
  localparam bit FI = 1'b1;
`else
  localparam bit FI = 1'b0;
`endif

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   fail_valid, repair_en, repair_clear;
  logic [ADDR_WIDTH-1:0]  fail_addr, inj_addr;
  logic                   inj_valid, inj_val, inj_clear;
  logic [FAULT_IDX_W-1:0] inj_slot;
  logic [BIT_IDX_W-1:0]   inj_bit;
  logic [COUNT_W-1:0]     repair_count;
  logic                   repair_overflow;
  int                     checks = 0;
  int                     errors = 0;
  int                     march_fails;

  mbisr_repair_mem_if bus ();

  mbisr_repair_mem dut (
    .clk             (clk),
    .rst             (rst),
    .mem             (bus),
    .fail_valid      (fail_valid),
    .fail_addr       (fail_addr),
    .repair_en       (repair_en),
    .repair_clear    (repair_clear),
    .inj_valid       (inj_valid),
    .inj_slot        (inj_slot),
    .inj_addr        (inj_addr),
    .inj_bit         (inj_bit),
    .inj_val         (inj_val),
    .inj_clear       (inj_clear),
    .repair_count    (repair_count),
    .repair_overflow (repair_overflow)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] d);
    bus.mem_en = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = a; bus.mem_wdata = d;
    tick();
    bus.mem_en = 1'b0; bus.mem_we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] exp);
    bus.mem_en = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = a;
    @(negedge clk);
    check_eq(tag, 32'(bus.mem_rdata), 32'(exp));
    tick();
    bus.mem_en = 1'b0;
  endtask

  task automatic fail(input logic [ADDR_WIDTH-1:0] a);
    fail_valid = 1'b1; fail_addr = a;
    tick();
    fail_valid = 1'b0;
  endtask

  task automatic inject(input logic [FAULT_IDX_W-1:0] s, input logic [ADDR_WIDTH-1:0] a,
                        input logic [BIT_IDX_W-1:0] b, input logic v);
    inj_valid = 1'b1; inj_slot = s; inj_addr = a; inj_bit = b; inj_val = v;
    tick();
    inj_valid = 1'b0;
  endtask

  // BIST-style read: a mismatch raises fail_valid for this address at the same edge.
  task automatic march_rd(input logic [ADDR_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] exp);
    bus.mem_en = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = a;
    @(negedge clk);
    if (bus.mem_rdata !== exp) begin
      march_fails++;
      fail_valid = 1'b1;
      fail_addr  = a;
    end
    tick();
    fail_valid = 1'b0;
    bus.mem_en = 1'b0;
  endtask

  task automatic march_pass();
    march_fails = 0;
    for (int a = 0; a < DEPTH; a++) wr(ADDR_WIDTH'(a), 8'h00);
    for (int a = 0; a < DEPTH; a++) begin march_rd(ADDR_WIDTH'(a), 8'h00); wr(ADDR_WIDTH'(a), 8'hFF); end
    for (int a = 0; a < DEPTH; a++) begin march_rd(ADDR_WIDTH'(a), 8'hFF); wr(ADDR_WIDTH'(a), 8'h00); end
    for (int a = DEPTH - 1; a >= 0; a--) begin march_rd(ADDR_WIDTH'(a), 8'h00); wr(ADDR_WIDTH'(a), 8'hFF); end
    for (int a = DEPTH - 1; a >= 0; a--) begin march_rd(ADDR_WIDTH'(a), 8'hFF); wr(ADDR_WIDTH'(a), 8'h00); end
    for (int a = 0; a < DEPTH; a++) march_rd(ADDR_WIDTH'(a), 8'h00);
  endtask

  initial begin
    rst = 1'b1;
    bus.mem_en = 1'b0; bus.mem_we = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0;
    fail_valid = 1'b0; fail_addr = '0; repair_en = 1'b1; repair_clear = 1'b0;
    inj_valid = 1'b0; inj_slot = '0; inj_addr = '0; inj_bit = '0; inj_val = 1'b0; inj_clear = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check_eq("reset_count", 32'(repair_count), 32'd0);
    check_eq("reset_ovf", 32'(repair_overflow), 32'd0);

    wr(5'd3, 8'hA5);
    rd("rd_a5", 5'd3, 8'hA5);
    bus.mem_en = 1'b0; bus.mem_addr = 5'd3;
    @(negedge clk);
    check_eq("en_low_zero", 32'(bus.mem_rdata), 32'h00);
    tick();

    inject(1'b0, 5'd7, 3'd2, 1'b1);
    wr(5'd7, 8'h00);
    rd("stuck_bit2", 5'd7, FI ? 8'h04 : 8'h00);
    inj_clear = 1'b1;
    inject(1'b0, 5'd7, 3'd2, 1'b1);
    inj_clear = 1'b0;
    rd("inj_clear_wins", 5'd7, 8'h00);

    inject(1'b0, 5'd7, 3'd2, 1'b1);
    fail(5'd7);
    check_eq("count_after_7", 32'(repair_count), 32'd1);
    rd("spare_zero_load", 5'd7, 8'h00);
    wr(5'd7, 8'h38);
    rd("spare_bypass", 5'd7, 8'h38);

    fail(5'd7);
    check_eq("dup_count", 32'(repair_count), 32'd1);
    fail(5'd9);
    check_eq("count_after_9", 32'(repair_count), 32'd2);
    check_eq("no_ovf_yet", 32'(repair_overflow), 32'd0);
    fail(5'd12);
    check_eq("count_full", 32'(repair_count), 32'd2);
    check_eq("ovf_set", 32'(repair_overflow), 32'd1);

    repair_clear = 1'b1; tick(); repair_clear = 1'b0;
    check_eq("clear_count", 32'(repair_count), 32'd0);
    check_eq("clear_keeps_ovf", 32'(repair_overflow), 32'd1);
    rd("unmapped_array", 5'd7, FI ? 8'h04 : 8'h00);

    fail(5'd3);
    rd("alloc_zero", 5'd3, 8'h00);
    bus.mem_en = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 5'd5; bus.mem_wdata = 8'h77;
    fail(5'd5);
    bus.mem_en = 1'b0; bus.mem_we = 1'b0;
    check_eq("count_two", 32'(repair_count), 32'd2);
    rd("alloc_wdata", 5'd5, 8'h77);

    repair_clear = 1'b1;
    fail(5'd5);
    repair_clear = 1'b0;
    check_eq("clear_beats_fail", 32'(repair_count), 32'd0);
    wr(5'd5, 8'h5A);
    rd("no_entry_5", 5'd5, 8'h5A);

    rst = 1'b1; tick(); rst = 1'b0;
    check_eq("rst_ovf", 32'(repair_overflow), 32'd0);
    inject(1'b0, 5'd7, 3'd2, 1'b1);
    inject(1'b1, 5'd20, 3'd5, 1'b0);
    march_pass();
    check_eq("march1_fails", 32'(march_fails), FI ? 32'd2 : 32'd0);
    check_eq("march1_count", 32'(repair_count), FI ? 32'd2 : 32'd0);
    march_pass();
    check_eq("march2_fails", 32'(march_fails), 32'd0);
    check_eq("march2_ovf", 32'(repair_overflow), 32'd0);

    wr(5'd7, 8'h5C);
    rd("pre_rst_7", 5'd7, 8'h5C);
    rst = 1'b1;
    bus.mem_en = 1'b1; bus.mem_we = 1'b1; bus.mem_addr = 5'd2; bus.mem_wdata = 8'h99;
    tick();
    rst = 1'b0; bus.mem_en = 1'b0; bus.mem_we = 1'b0;
    check_eq("midrst_count", 32'(repair_count), 32'd0);
    check_eq("midrst_ovf", 32'(repair_overflow), 32'd0);
    rd("midrst_wr_dropped", 5'd2, 8'h00);
    rd("midrst_map_empty", 5'd7, FI ? 8'h00 : 8'h5C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
